// File: rtl/kc705_button_input.sv
// Debounce and event generation for the KC705 GPIO push buttons.
// Each channel has its own synchronizer, debounce FSM and long-press timer.
module kc705_button_input #(
  parameter int NUM_BTN           = 5,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 200000000
) (
  input  logic               clk_200mhz,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync;

  always_ff @(posedge clk_200mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      state_t              state, state_next;
      logic [DEB_W-1:0]    deb_cnt, deb_cnt_next;
      logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
      logic                long_done, long_done_next;
      logic                level_reg, level_next;
      logic                press_reg, press_next;
      logic                release_reg, release_next;
      logic                long_reg, long_next;

      always_ff @(posedge clk_200mhz or negedge rst_n) begin
        if (!rst_n) begin
          state       <= IDLE;
          deb_cnt     <= '0;
          hold_cnt    <= '0;
          long_done   <= 1'b0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          long_reg    <= 1'b0;
        end else begin
          state       <= state_next;
          deb_cnt     <= deb_cnt_next;
          hold_cnt    <= hold_cnt_next;
          long_done   <= long_done_next;
          level_reg   <= level_next;
          press_reg   <= press_next;
          release_reg <= release_next;
          long_reg    <= long_next;
        end
      end

      always_comb begin
        state_next     = state;
        deb_cnt_next   = deb_cnt;
        hold_cnt_next  = hold_cnt;
        long_done_next = long_done;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;

        // Hold time keeps running through release bounces; saturates once fired.
        if (state == PRESSED || state == RELEASE_WAIT) begin
          if (hold_cnt == HOLD_LAST) begin
            if (!long_done) begin
              long_next      = 1'b1;
              long_done_next = 1'b1;
            end
          end else begin
            hold_cnt_next = hold_cnt + HOLD_W'(1);
          end
        end

        case (state)
          IDLE: begin
            if (sync[gi]) begin
              state_next   = PRESS_WAIT;
              deb_cnt_next = '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync[gi]) begin
              state_next = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              state_next     = PRESSED;
              level_next     = 1'b1;
              press_next     = 1'b1;
              hold_cnt_next  = '0;
              long_done_next = 1'b0;
            end else begin
              deb_cnt_next = deb_cnt + DEB_W'(1);
            end
          end
          PRESSED: begin
            if (!sync[gi]) begin
              state_next   = RELEASE_WAIT;
              deb_cnt_next = '0;
            end
          end
          RELEASE_WAIT: begin
            if (sync[gi]) begin
              state_next = PRESSED;
            end else if (deb_cnt == DEB_LAST) begin
              state_next   = IDLE;
              level_next   = 1'b0;
              release_next = 1'b1;
            end else begin
              deb_cnt_next = deb_cnt + DEB_W'(1);
            end
          end
          default: state_next = IDLE;
        endcase
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_long[gi]    = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_kc705_button_input.sv
// Randomized and directed check of kc705_button_input against a run-length
// reference model (a change is accepted after DEB+1 consecutive differing samples).
`timescale 1ns/1ps
module tb_kc705_button_input;

  localparam int N    = 5;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  kc705_button_input #(
    .NUM_BTN(N),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk_200mhz(clk),
    .rst_n(rst_n),
    .btn_raw(raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] exp_level, exp_press, exp_release, exp_long;
  int run_len[N];
  int press_edge[N];

  // observed event statistics
  int press_cnt[N], release_cnt[N], long_cnt[N];
  int last_press_cyc[N], last_long_cyc[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
    for (int i = 0; i < N; i++) begin
      run_len[i]    = 0;
      press_edge[i] = 0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] smp;
    @(posedge clk);
    cyc++;
    exp_press = '0; exp_release = '0; exp_long = '0;
    if (rst_n) begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int i = 0; i < N; i++) begin
        if (exp_level[i] && (cyc - press_edge[i] == LONG)) exp_long[i] = 1'b1;
        if (smp[i] != exp_level[i]) begin
          run_len[i]++;
          if (run_len[i] == DEB + 1) begin
            run_len[i]   = 0;
            exp_level[i] = smp[i];
            if (smp[i]) begin
              exp_press[i]  = 1'b1;
              press_edge[i] = cyc;
            end else begin
              exp_release[i] = 1'b1;
            end
          end
        end else begin
          run_len[i] = 0;
        end
      end
    end
    @(negedge clk);
    check("level",   32'(btn_level),   32'(exp_level));
    check("press",   32'(btn_press),   32'(exp_press));
    check("release", 32'(btn_release), 32'(exp_release));
    check("long",    32'(btn_long),    32'(exp_long));
    for (int i = 0; i < N; i++) begin
      if (btn_press[i]) begin press_cnt[i]++; last_press_cyc[i] = cyc; end
      if (btn_release[i]) release_cnt[i]++;
      if (btn_long[i]) begin long_cnt[i]++; last_long_cyc[i] = cyc; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    logic [4:0] bounce_on;
    logic [4:0] bounce_off;
    bounce_on  = 5'b01101;  // applied LSB first: 1,0,1,1,0
    bounce_off = 5'b10010;  // applied LSB first: 0,1,0,0,1

    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0;
      last_press_cyc[i] = -1; last_long_cyc[i] = -1;
    end
    rst_n = 1'b0;
    raw   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level",   32'(btn_level),   0);
    check("rst_press",   32'(btn_press),   0);
    check("rst_release", 32'(btn_release), 0);
    check("rst_long",    32'(btn_long),    0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: clean press on channel 0
    raw[0] = 1'b1;
    k = cyc + 1;
    repeat (8) tick();
    check("t1_press_cyc", last_press_cyc[0], k + 6);
    check("t1_press_cnt", press_cnt[0], 1);
    check("t1_level", 32'(btn_level), 32'b00001);
    raw[0] = 1'b0;
    repeat (8) tick();
    check("t1_release_cnt", release_cnt[0], 1);

    // 2: 3-cycle glitch on channel 1
    raw[1] = 1'b1;
    repeat (3) tick();
    raw[1] = 1'b0;
    repeat (8) tick();
    check("t2_press_cnt", press_cnt[1], 0);
    check("t2_release_cnt", release_cnt[1], 0);
    check("t2_level", 32'(btn_level[1]), 0);

    // 3: bouncy press and release on channel 2
    for (int b = 0; b < 5; b++) begin
      raw[2] = bounce_on[b];
      tick();
    end
    raw[2] = 1'b1;
    k = cyc + 1;
    repeat (12) tick();
    check("t3_press_cnt", press_cnt[2], 1);
    check("t3_press_cyc", last_press_cyc[2], k + 6);
    for (int b = 0; b < 5; b++) begin
      raw[2] = bounce_off[b];
      tick();
    end
    raw[2] = 1'b0;
    repeat (12) tick();
    check("t3_release_cnt", release_cnt[2], 1);
    check("t3_press_cnt_after", press_cnt[2], 1);

    // 4: long press on channel 3
    raw[3] = 1'b1;
    n = 0;
    while (press_cnt[3] == 0 && n < 20) begin
      tick();
      n++;
    end
    check("t4_press_seen", press_cnt[3], 1);
    repeat (40) tick();
    check("t4_long_cnt", long_cnt[3], 1);
    check("t4_long_cyc", last_long_cyc[3], last_press_cyc[3] + LONG);
    raw[3] = 1'b0;
    repeat (10) tick();
    check("t4_release_cnt", release_cnt[3], 1);
    check("t4_long_cnt_after", long_cnt[3], 1);

    // 5: simultaneous press, then asynchronous reset while held
    raw[0] = 1'b1;
    raw[4] = 1'b1;
    k = cyc + 1;
    repeat (8) tick();
    check("t5_press0_cyc", last_press_cyc[0], k + 6);
    check("t5_press4_cyc", last_press_cyc[4], k + 6);
    check("t5_pre_level", 32'(btn_level), 32'b10001);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_level",   32'(btn_level),   0);
    check("t5_async_press",   32'(btn_press),   0);
    check("t5_async_release", 32'(btn_release), 0);
    check("t5_async_long",    32'(btn_long),    0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    repeat (8) tick();
    check("t5_repress0_cyc", last_press_cyc[0], k + 6);
    check("t5_repress4_cyc", last_press_cyc[4], k + 6);
    raw = '0;
    repeat (10) tick();

    // randomized: fast bouncing, then slow toggling for long presses
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, (r < 1500) ? 5 : 30) == 0) raw[i] = ~raw[i];
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kc705_button_input.md
Name: kc705_button_input

Overview:
- Input-side companion to the board-test LED driver.
- Takes raw KC705 GPIO push buttons (N/E/S/W/C, active-high, asynchronous to the FPGA clock) and produces clean per-button signals: level, press, release and long-press events, all in the 200 MHz domain.
- Sits between the top-level pads and any board-test or UI logic that reacts to buttons.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a change (5 ms at 200 MHz); must be >= 1.
- LONG_PRESS_CYCLES, 200000000, cycles held before a long-press event (1 s at 200 MHz); must be >= 1.

Ports:
- clk_200mhz  input  1  system clock (200 MHz, single-ended after IBUFGDS).
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  NUM_BTN  raw pad levels, active-high, asynchronous.
- btn_level  output  NUM_BTN  debounced level, 1 = pressed.
- btn_press  output  NUM_BTN  1-cycle pulse on accepted press.
- btn_release  output  NUM_BTN  1-cycle pulse on accepted release.
- btn_long  output  NUM_BTN  1-cycle pulse, at most once per press, when hold time reaches LONG_PRESS_CYCLES.

Behaviour:
- Clock and reset: one clock, clk_200mhz. rst_n is asynchronous and active-low.
- Reset state: all flops clear, including synchronizers, counters and FSMs. Every output is 0. Each FSM is in IDLE.
- Synchronizer: each bit of btn_raw passes through a 2-flop synchronizer whose output is sync[i]. The FSM samples sync[i] only.
- Independence: channels are independent, with no shared counters.
- Per-channel counters:
  - deb_cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - hold_cnt, width $clog2(LONG_PRESS_CYCLES+1), saturating.
  - long_done flag.
- FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Evaluated on every clock edge:
  - IDLE: if sync=1, go to PRESS_WAIT with deb_cnt=0.
  - PRESS_WAIT:
    - sync=0: go to IDLE, no pulse.
    - sync=1 and deb_cnt==DEBOUNCE_CYCLES-1: go to PRESSED. Set level=1, pulse press. Clear hold_cnt and long_done.
    - Otherwise: deb_cnt++.
  - PRESSED: if sync=0, go to RELEASE_WAIT with deb_cnt=0.
  - RELEASE_WAIT:
    - sync=1: go back to PRESSED, no pulse.
    - sync=0 and deb_cnt==DEBOUNCE_CYCLES-1: go to IDLE. Set level=0, pulse release.
    - Otherwise: deb_cnt++.
- Latency: let edge k be the first edge whose synchronizer stage 1 captures raw=1, with raw stable afterwards. The FSM enters PRESS_WAIT at edge k+2. btn_level rises and btn_press is high for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES. Release is symmetric.
- Glitch rejection: a raw glitch shorter than the debounce window produces no pulse and no level change. Each bounce restarts the window from deb_cnt=0.
- Long press:
  - hold_cnt increments every cycle in PRESSED or RELEASE_WAIT, i.e. a release bounce does not reset the hold time.
  - When hold_cnt reaches LONG_PRESS_CYCLES-1 and long_done=0, pulse btn_long for one cycle, set long_done, and saturate hold_cnt.
  - hold_cnt and long_done clear on entry to PRESSED from PRESS_WAIT.
- Long press vs release: if the long-press threshold and the release acceptance fall on the same edge, both btn_long and btn_release pulse in the same cycle.
- Pulse exclusivity: btn_press and btn_release never pulse in the same cycle for one channel.
- Registered outputs: all outputs are registered, with no combinational path from btn_raw.
- Reset mid-operation: asserting rst_n=0 in any state forces outputs to 0 immediately, asynchronously. After deassertion, a button that is still held produces a fresh btn_press after the normal latency.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_BTN=5):
1. Clean press, reset released, btn_raw[0] 0→1 captured at edge k → btn_press[0] high only in the cycle after edge k+6. btn_level[0]=1 from then on. Other channels stay 0.
2. Glitch rejection, btn_raw[1] high for 3 cycles then low → btn_level, btn_press and btn_release on channel 1 stay 0 throughout.
3. Bouncy press on btn_raw[2], pattern 1,0,1,1,0 followed by steady 1 → exactly one btn_press[2], arriving 6 edges after the first edge of the steady 1. Release bounces produce exactly one btn_release[2].
4. Long press, btn_raw[3] held for 40 cycles after acceptance → btn_long[3] pulses once, 20 cycles after btn_press[3], with no repeat. A release then gives one btn_release[3].
5. Simultaneous and reset:
   - btn_raw[0] and btn_raw[4] rise on the same edge → press pulses occur on the same cycle.
   - rst_n pulled low while channel 0 is PRESSED → all outputs 0 immediately.
   - Release rst_n with raw still high → btn_press[0] fires again after the normal latency.
